// File: rtl/count_tracker.sv
// rtl/count_tracker.sv - receive-side tracker for an up/down count stream
//
// Purpose:
//   Samples a count stream on enabled cycles. It reconstructs the counting
//   direction, detects legal wrap-around, flags illegal steps with a
//   saturating error counter, and emits a sync pulse when a tracked sample
//   reaches SYNC_VAL.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   ena        in   sample qualifier for count_in
//   count_in   in   [WIDTH-1:0] observed count value
//   clr_err    in   synchronous clear of step_err / err_count
//   dir_up     out  last legal move was up (1) or down (0)
//   dir_valid  out  a legal +/-1 step seen since reset, resync or error
//   holding    out  last sample equalled the previous one
//   wrap_pulse out  one-cycle pulse on a legal wrap
//   sync_pulse out  one-cycle pulse when a tracked sample equals SYNC_VAL
//   step_err   out  sticky illegal-step flag
//   err_count  out  [ERR_CNT_W-1:0] saturating illegal-step count

module count_tracker #(
  parameter int               WIDTH           = 17,
  parameter logic [WIDTH-1:0] SYNC_VAL        = '0,
  parameter bit               ALLOW_ZERO_JUMP = 1'b1,
  parameter int               ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clr_err,
  output logic                 dir_up,
  output logic                 dir_valid,
  output logic                 holding,
  output logic                 wrap_pulse,
  output logic                 sync_pulse,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
  typedef enum logic [2:0] {STEP_UP, STEP_DOWN, STEP_HOLD, STEP_RESYNC, STEP_ERR} step_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  state_t               state, state_n;
  logic [WIDTH-1:0]     prev, prev_n;
  logic                 dir_up_n, dir_valid_n, holding_n;
  logic                 wrap_n, sync_n, step_err_n;
  logic [ERR_CNT_W-1:0] err_count_n, err_base;
  logic [WIDTH-1:0]     diff;
  step_t                step;

  // Classify the current sample against the previous one. Unit moves are
  // checked first so that the up-wrap to 0 is UP rather than RESYNC.
  always_comb begin
    diff = count_in - prev;
    if (diff == WIDTH'(1))
      step = STEP_UP;
    else if (diff == MAX_VAL)
      step = STEP_DOWN;
    else if (diff == '0)
      step = STEP_HOLD;
    else if (ALLOW_ZERO_JUMP && (count_in == '0))
      step = STEP_RESYNC;
    else
      step = STEP_ERR;
  end

  // An error in the same cycle as clr_err counts from zero, so the error wins.
  always_comb begin
    err_base = clr_err ? '0 : err_count;
  end

  always_comb begin
    state_n     = state;
    prev_n      = prev;
    dir_up_n    = dir_up;
    dir_valid_n = dir_valid;
    holding_n   = holding;
    wrap_n      = 1'b0;
    sync_n      = 1'b0;
    step_err_n  = clr_err ? 1'b0 : step_err;
    err_count_n = err_base;

    if (ena) begin
      prev_n = count_in;
      if (state == IDLE) begin
        // First sample only establishes the reference value.
        state_n = TRACK;
      end else begin
        case (step)
          STEP_UP, STEP_DOWN: begin
            state_n     = TRACK;
            dir_up_n    = (step == STEP_UP);
            dir_valid_n = 1'b1;
            holding_n   = 1'b0;
            sync_n      = (count_in == SYNC_VAL);
            wrap_n      = (step == STEP_UP) ? (count_in == '0) : (count_in == MAX_VAL);
          end
          STEP_HOLD: begin
            state_n   = HOLD;
            holding_n = 1'b1;
          end
          STEP_RESYNC: begin
            state_n     = TRACK;
            dir_valid_n = 1'b0;
            holding_n   = 1'b0;
            sync_n      = (count_in == SYNC_VAL);
          end
          default: begin
            state_n     = TRACK;
            dir_valid_n = 1'b0;
            holding_n   = 1'b0;
            step_err_n  = 1'b1;
            if (err_base != '1)
              err_count_n = err_base + ERR_CNT_W'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      dir_up     <= 1'b0;
      dir_valid  <= 1'b0;
      holding    <= 1'b0;
      wrap_pulse <= 1'b0;
      sync_pulse <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      dir_up     <= dir_up_n;
      dir_valid  <= dir_valid_n;
      holding    <= holding_n;
      wrap_pulse <= wrap_n;
      sync_pulse <= sync_n;
      step_err   <= step_err_n;
      err_count  <= err_count_n;
    end
  end

endmodule

// File: tb/tb_count_tracker.sv
// tb/tb_count_tracker.sv - randomized and directed bench for count_tracker

module tb_count_tracker;

  localparam int MOD  = 1 << 17;
  localparam int MAXV = MOD - 1;
  localparam int SYNC = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [16:0] count_in = '0;
  logic        clr_err = 1'b0;

  logic [1:0]  dir_up_o, dir_valid_o, holding_o, wrap_o, sync_o, err_o;
  logic [7:0]  cnt_o [2];

  int total = 0;
  int bad   = 0;

  // Reference state, index 0 = zero-jump resync allowed, 1 = not allowed.
  bit m_started [2];
  int m_prev    [2];
  bit m_dir_up  [2];
  bit m_dv      [2];
  bit m_hold    [2];
  bit m_wrap    [2];
  bit m_sync    [2];
  bit m_err     [2];
  int m_cnt     [2];
  bit allow     [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  count_tracker #(.WIDTH(17), .SYNC_VAL(17'd0), .ALLOW_ZERO_JUMP(1'b1), .ERR_CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .count_in(count_in), .clr_err(clr_err),
    .dir_up(dir_up_o[0]), .dir_valid(dir_valid_o[0]), .holding(holding_o[0]),
    .wrap_pulse(wrap_o[0]), .sync_pulse(sync_o[0]), .step_err(err_o[0]),
    .err_count(cnt_o[0])
  );

  count_tracker #(.WIDTH(17), .SYNC_VAL(17'd0), .ALLOW_ZERO_JUMP(1'b0), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .count_in(count_in), .clr_err(clr_err),
    .dir_up(dir_up_o[1]), .dir_valid(dir_valid_o[1]), .holding(holding_o[1]),
    .wrap_pulse(wrap_o[1]), .sync_pulse(sync_o[1]), .step_err(err_o[1]),
    .err_count(cnt_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 0; m_prev[i] = 0; m_dir_up[i] = 0; m_dv[i] = 0;
      m_hold[i] = 0; m_wrap[i] = 0; m_sync[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int c, d;
    c = int'(count_in);
    if (clr_err) begin
      m_err[i] = 0;
      m_cnt[i] = 0;
    end
    m_wrap[i] = 0;
    m_sync[i] = 0;
    if (!ena) return;
    if (!m_started[i]) begin
      m_started[i] = 1;
      m_prev[i] = c;
      return;
    end
    d = (c - m_prev[i] + MOD) % MOD;
    if (d == 1 || d == MOD - 1) begin
      m_dir_up[i] = (d == 1);
      m_dv[i]     = 1;
      m_hold[i]   = 0;
      m_wrap[i]   = (d == 1) ? (c == 0) : (c == MAXV);
      m_sync[i]   = (c == SYNC);
    end else if (d == 0) begin
      m_hold[i] = 1;
    end else if (allow[i] && c == 0) begin
      m_dv[i]   = 0;
      m_hold[i] = 0;
      m_sync[i] = (c == SYNC);
    end else begin
      m_err[i]  = 1;
      m_cnt[i]  = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
      m_dv[i]   = 0;
      m_hold[i] = 0;
    end
    m_prev[i] = c;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dir_up[%0d]", i),    int'(dir_up_o[i]),    int'(m_dir_up[i]));
      chk($sformatf("dir_valid[%0d]", i), int'(dir_valid_o[i]), int'(m_dv[i]));
      chk($sformatf("holding[%0d]", i),   int'(holding_o[i]),   int'(m_hold[i]));
      chk($sformatf("wrap[%0d]", i),      int'(wrap_o[i]),      int'(m_wrap[i]));
      chk($sformatf("sync[%0d]", i),      int'(sync_o[i]),      int'(m_sync[i]));
      chk($sformatf("step_err[%0d]", i),  int'(err_o[i]),       int'(m_err[i]));
      chk($sformatf("err_count[%0d]", i), int'(cnt_o[i]),       m_cnt[i]);
    end
  endtask

  // One clock cycle: drive on the falling edge, advance the model on the
  // rising edge, compare shortly after.
  task automatic cyc(input bit e, input int c, input bit clr);
    @(negedge clk);
    rst = 1'b0; ena = e; count_in = 17'(c); clr_err = clr;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    rst = 1'b1; ena = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
  endtask

  int cur;
  int r;

  initial begin
    model_reset();
    rst_cyc();
    rst_cyc();
    chk("reset err_count", int'(cnt_o[0]), 0);
    chk("reset dir_valid", int'(dir_valid_o[0]), 0);

    // Plain up-count from 0.
    cyc(1, 0, 0);
    chk("first sample dir_valid", int'(dir_valid_o[0]), 0);
    cyc(1, 1, 0);
    chk("second sample dir_valid", int'(dir_valid_o[0]), 1);
    cyc(1, 2, 0);
    cyc(1, 3, 0);
    chk("up dir_up", int'(dir_up_o[0]), 1);
    chk("up step_err", int'(err_o[0]), 0);

    // Up wrap with sync at 0.
    rst_cyc();
    cyc(1, 'h1FFFE, 0);
    cyc(1, 'h1FFFF, 0);
    cyc(1, 0, 0);
    chk("upwrap wrap", int'(wrap_o[0]), 1);
    chk("upwrap sync", int'(sync_o[0]), 1);
    chk("upwrap no err strict", int'(err_o[1]), 0);
    cyc(1, 1, 0);
    chk("upwrap pulse drop", int'(wrap_o[0]), 0);

    // Down wrap then hold.
    rst_cyc();
    cyc(1, 2, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    chk("down sync at 0", int'(sync_o[0]), 1);
    cyc(1, 'h1FFFF, 0);
    chk("downwrap wrap", int'(wrap_o[0]), 1);
    chk("downwrap dir_up", int'(dir_up_o[0]), 0);
    cyc(1, 5, 0);
    cyc(1, 5, 0);
    cyc(1, 5, 0);
    chk("hold holding", int'(holding_o[0]), 1);

    // Illegal jump, recovery, clear.
    rst_cyc();
    cyc(1, 10, 0);
    cyc(1, 11, 0);
    cyc(1, 40, 0);
    chk("jump step_err", int'(err_o[0]), 1);
    chk("jump err_count", int'(cnt_o[0]), 1);
    chk("jump dir_valid", int'(dir_valid_o[0]), 0);
    cyc(1, 40, 0);
    cyc(1, 41, 0);
    chk("recover dir_valid", int'(dir_valid_o[0]), 1);
    cyc(0, 41, 1);
    chk("clr step_err", int'(err_o[0]), 0);
    chk("clr err_count", int'(cnt_o[0]), 0);

    // Counter reset to 0 mid-stream.
    rst_cyc();
    cyc(1, 50, 0);
    cyc(1, 51, 0);
    cyc(1, 0, 0);
    chk("resync no err", int'(err_o[0]), 0);
    chk("resync sync", int'(sync_o[0]), 1);
    chk("strict zero jump err", int'(err_o[1]), 1);

    // Error coinciding with clr_err.
    cyc(1, 77, 0);
    cyc(1, 900, 1);
    chk("clr+err count", int'(cnt_o[0]), 1);

    // Saturation.
    for (int k = 0; k < 300; k++) cyc(1, (k % 2) ? 100 : 300, 0);
    chk("saturate", int'(cnt_o[0]), 255);

    // Reset asserted between edges takes effect immediately.
    @(negedge clk);
    ena = 1'b1; count_in = 17'd7;
    #2 rst = 1'b1;
    #1;
    chk("async rst err_count", int'(cnt_o[0]), 0);
    chk("async rst step_err", int'(err_o[0]), 0);
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
    cyc(1, 7, 0);
    chk("post rst first dv", int'(dir_valid_o[0]), 0);
    cyc(1, 8, 0);
    chk("post rst second dv", int'(dir_valid_o[0]), 1);

    // Randomized stream.
    cur = 8;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_cyc();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 35)      cur = (cur + 1) % MOD;
        else if (r < 60) cur = (cur + MOD - 1) % MOD;
        else if (r < 72) cur = cur;
        else if (r < 80) cur = 0;
        else if (r < 85) cur = MAXV;
        else if (r < 90) cur = 1;
        else             cur = $urandom_range(0, MAXV);
        cyc($urandom_range(0, 9) < 8, cur, $urandom_range(0, 19) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
